mult_checker: RTL and testbench
===============================

MULT_CHECKER -- requirements
Module: mult_checker

Interface
REQ-001 Parameter WIDTH, default 8: operand width; the product is 2*WIDTH bits.
REQ-002 Parameter COVER_BITS, default 4: operand values below 2^COVER_BITS are coverage-tracked; COVER_BITS SHALL be at most WIDTH.
REQ-003 Parameter MAX_LAT, default 40: maximum number of cycles allowed from start acceptance to done.
REQ-004 Parameter CNT_W, default 16: width of each error counter.
REQ-005 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-006 reset_i  in  1  checker reset; synchronous, active-high.
REQ-007 dut_rst_i  in  1  observed DUT reset, active-high.
REQ-008 start_i, ready_i, done_i  in  1 each  observed DUT handshake signals.
REQ-009 phase_i  in  2  observed DUT phase: 0 = IDLE, 1 = ADD, 2 = SHIFT, 3 = DONE.
REQ-010 multiplicand_i, multiplier_i  in  WIDTH each  observed operands.
REQ-011 product_i  in  2*WIDTH  observed DUT result.
REQ-012 bp_err_o, nr_err_o, to_err_o, sp_err_o  out  1 each  one-cycle error pulses: bad product, not ready, timeout, spurious done.
REQ-013 bp_cnt_o, nr_cnt_o, to_cnt_o, sp_cnt_o  out  CNT_W each  saturating error counts.
REQ-014 cover_hits_o  out  2*COVER_BITS+1  number of distinct operand pairs covered.
REQ-015 cover_full_o  out  1  all 2^(2*COVER_BITS) operand pairs covered.
REQ-016 cover_evt_o  out  4  sticky event covers: [0] reset in ADD, [1] reset in SHIFT, [2] start in ADD, [3] start in SHIFT.
REQ-017 busy_o  out  1  the checker has an outstanding operation.

Function
REQ-018 The checker SHALL implement FSM states IDLE and BUSY, with busy_o = (state == BUSY).
REQ-019 Start acceptance is start_i && ready_i at a rising edge; on acceptance the checker SHALL latch both operands, clear the latency counter, and enter BUSY.
REQ-020 When start_i && !ready_i at an edge, the checker SHALL pulse nr_err_o and SHALL NOT latch operands or change state.
REQ-021 When done_i is high at an edge in BUSY, the checker SHALL compare product_i with the latched multiplicand * multiplier (full 2*WIDTH bits), pulse bp_err_o on mismatch, and enter IDLE.
REQ-022 When done_i is high at an edge in IDLE, the checker SHALL pulse sp_err_o.
REQ-023 In BUSY the latency counter SHALL increment every cycle; when it reaches MAX_LAT without done_i, the checker SHALL pulse to_err_o and enter IDLE.
REQ-024 When done_i and an accepted start occur at the same edge in BUSY, the checker SHALL evaluate done first, then accept the start, and remain in BUSY with the new operands.
REQ-025 When dut_rst_i is high, the checker SHALL return to IDLE without any error pulse and ignore start_i and done_i that edge.
REQ-026 When dut_rst_i is high and phase_i is 1 or 2, the checker SHALL set cover_evt_o[0] or cover_evt_o[1] respectively.
REQ-027 When start_i is high and phase_i is 1 or 2, the checker SHALL set cover_evt_o[2] or cover_evt_o[3] respectively, regardless of ready_i.
REQ-028 On start acceptance with both operands below 2^COVER_BITS, the checker SHALL set bitmap bit {multiplicand[COVER_BITS-1:0], multiplier[COVER_BITS-1:0]}.
REQ-029 cover_hits_o SHALL increment only when that bitmap bit was previously clear.
REQ-030 cover_full_o SHALL be high exactly when cover_hits_o == 2^(2*COVER_BITS).
REQ-031 All error pulses SHALL be registered, appearing for one cycle in the cycle after the triggering edge.
REQ-032 Each counter SHALL increment in the same cycle as its pulse and hold at all-ones on saturation.
REQ-033 Several different error pulses MAY assert in the same cycle, each counted independently.

Reset
REQ-034 While reset_i is high at an edge, the checker SHALL enter IDLE and clear all outputs, counters, the latency counter, the bitmap, and cover_evt_o; reset_i overrides dut_rst_i and all observed events.
REQ-035 Coverage and counters SHALL survive dut_rst_i; only reset_i clears them.

Verification
REQ-036 Accept start with 3 and 5, then done with product 15 after 10 cycles -> no pulses, busy_o 1->0, cover_hits_o = 1.
REQ-037 Accept start with 7 and 9, then done with product 62 -> bp_err_o pulses once, bp_cnt_o = 1, other counters stay 0.
REQ-038 start_i high, ready_i low, phase_i = 1 -> nr_err_o pulses, cover_evt_o[2] set, busy_o stays 0.
REQ-039 Accept start, withhold done for 40 cycles -> to_err_o pulses once at the 40th cycle, checker returns to IDLE; a later done -> sp_err_o pulses.
REQ-040 In BUSY, dut_rst_i with phase_i = 2 -> no error pulse, IDLE, cover_evt_o[1] set, counters unchanged.
REQ-041 Sweep all 256 operand pairs 0..15 x 0..15 with correct products -> cover_full_o = 1 and cover_hits_o = 256; repeated pairs do not increment cover_hits_o.

Source files
------------

// File: rtl/mult_checker.sv
// Protocol and result checker for an observed sequential multiplier.
// Flags bad products, starts while not ready, timeouts and spurious done; tracks operand-pair coverage.
module mult_checker #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned COVER_BITS = 4,
   parameter int unsigned MAX_LAT    = 40,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    dut_rst_i,
   input  logic                    start_i,
   input  logic                    ready_i,
   input  logic                    done_i,
   input  logic [1:0]              phase_i,
   input  logic [WIDTH-1:0]        multiplicand_i,
   input  logic [WIDTH-1:0]        multiplier_i,
   input  logic [2*WIDTH-1:0]      product_i,
   output logic                    bp_err_o,
   output logic                    nr_err_o,
   output logic                    to_err_o,
   output logic                    sp_err_o,
   output logic [CNT_W-1:0]        bp_cnt_o,
   output logic [CNT_W-1:0]        nr_cnt_o,
   output logic [CNT_W-1:0]        to_cnt_o,
   output logic [CNT_W-1:0]        sp_cnt_o,
   output logic [2*COVER_BITS:0]   cover_hits_o,
   output logic                    cover_full_o,
   output logic [3:0]              cover_evt_o,
   output logic                    busy_o
);

   localparam int unsigned PW     = 2 * WIDTH;
   localparam int unsigned CB     = 2 * COVER_BITS;
   localparam int unsigned HW     = CB + 1;
   localparam int unsigned NPAIRS = 1 << CB;
   localparam int unsigned LW     = $clog2(MAX_LAT + 1);

   localparam logic [1:0] PH_ADD   = 2'd1;
   localparam logic [1:0] PH_SHIFT = 2'd2;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    mcand_q, mplier_q;
   logic [LW-1:0]       lat_q, lat_d;
   logic [NPAIRS-1:0]   bitmap_q;
   logic [CB-1:0]       cov_idx;
   logic [HW-1:0]       hits_d;
   logic [3:0]          evt_d;
   logic                accept, new_hit;
   logic                bp_d, nr_d, to_d, sp_d;

   assign cov_idx = {multiplicand_i[COVER_BITS-1:0], multiplier_i[COVER_BITS-1:0]};

   // Next state, latency and event decode; done/timeout are resolved before a same-edge start.
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      accept  = 1'b0;
      bp_d    = 1'b0;
      nr_d    = 1'b0;
      to_d    = 1'b0;
      sp_d    = 1'b0;
      evt_d   = cover_evt_o;
      new_hit = 1'b0;
      if (dut_rst_i) begin
         evt_d[0] = cover_evt_o[0] | (phase_i == PH_ADD);
         evt_d[1] = cover_evt_o[1] | (phase_i == PH_SHIFT);
         state_d  = IDLE;
         lat_d    = '0;
      end else begin
         if (start_i) begin
            evt_d[2] = cover_evt_o[2] | (phase_i == PH_ADD);
            evt_d[3] = cover_evt_o[3] | (phase_i == PH_SHIFT);
         end
         if (state_q == BUSY) begin
            if (done_i) begin
               bp_d    = (product_i != (PW'(mcand_q) * PW'(mplier_q)));
               state_d = IDLE;
            end else if (lat_q == LW'(MAX_LAT - 1)) begin
               to_d    = 1'b1;
               state_d = IDLE;
            end else begin
               lat_d = lat_q + LW'(1);
            end
         end else if (done_i) begin
            sp_d = 1'b1;
         end
         if (start_i) begin
            if (ready_i) begin
               accept  = 1'b1;
               state_d = BUSY;
               lat_d   = '0;
            end else begin
               nr_d = 1'b1;
            end
         end
      end
      new_hit = accept
              && ((multiplicand_i >> COVER_BITS) == '0)
              && ((multiplier_i >> COVER_BITS) == '0)
              && !bitmap_q[cov_idx];
      hits_d  = cover_hits_o + HW'(new_hit);
   end

   // State, operand, pulse, counter and coverage registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         mcand_q      <= '0;
         mplier_q     <= '0;
         lat_q        <= '0;
         bitmap_q     <= '0;
         bp_err_o     <= 1'b0;
         nr_err_o     <= 1'b0;
         to_err_o     <= 1'b0;
         sp_err_o     <= 1'b0;
         bp_cnt_o     <= '0;
         nr_cnt_o     <= '0;
         to_cnt_o     <= '0;
         sp_cnt_o     <= '0;
         cover_hits_o <= '0;
         cover_full_o <= 1'b0;
         cover_evt_o  <= '0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         bp_err_o <= bp_d;
         nr_err_o <= nr_d;
         to_err_o <= to_d;
         sp_err_o <= sp_d;
         if (accept) begin
            mcand_q  <= multiplicand_i;
            mplier_q <= multiplier_i;
         end
         if (new_hit) bitmap_q[cov_idx] <= 1'b1;
         cover_hits_o <= hits_d;
         cover_full_o <= (hits_d == HW'(NPAIRS));
         cover_evt_o  <= evt_d;
         if (bp_d && (bp_cnt_o != '1)) bp_cnt_o <= bp_cnt_o + CNT_W'(1);
         if (nr_d && (nr_cnt_o != '1)) nr_cnt_o <= nr_cnt_o + CNT_W'(1);
         if (to_d && (to_cnt_o != '1)) to_cnt_o <= to_cnt_o + CNT_W'(1);
         if (sp_d && (sp_cnt_o != '1)) sp_cnt_o <= sp_cnt_o + CNT_W'(1);
      end
   end

   assign busy_o = (state_q == BUSY);

endmodule

// File: tb/tb_mult_checker.sv
// Self-checking bench for mult_checker: directed vector table, corner sequences and randomized traffic
// compared against an integer-level reference model.
module tb_mult_checker;

   localparam int W  = 8;
   localparam int C  = 4;
   localparam int ML = 40;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            reset_i = 1'b0, dut_rst_i = 1'b0;
   logic            start_i = 1'b0, ready_i = 1'b0, done_i = 1'b0;
   logic [1:0]      phase_i = 2'd0;
   logic [W-1:0]    multiplicand_i = '0, multiplier_i = '0;
   logic [2*W-1:0]  product_i = '0;
   logic            bp_err_o, nr_err_o, to_err_o, sp_err_o;
   logic [CW-1:0]   bp_cnt_o, nr_cnt_o, to_cnt_o, sp_cnt_o;
   logic [2*C:0]    cover_hits_o;
   logic            cover_full_o;
   logic [3:0]      cover_evt_o;
   logic            busy_o;

   mult_checker #(.WIDTH(W), .COVER_BITS(C), .MAX_LAT(ML), .CNT_W(CW)) dut (
      .clk_i(clk), .reset_i(reset_i), .dut_rst_i(dut_rst_i),
      .start_i(start_i), .ready_i(ready_i), .done_i(done_i), .phase_i(phase_i),
      .multiplicand_i(multiplicand_i), .multiplier_i(multiplier_i), .product_i(product_i),
      .bp_err_o(bp_err_o), .nr_err_o(nr_err_o), .to_err_o(to_err_o), .sp_err_o(sp_err_o),
      .bp_cnt_o(bp_cnt_o), .nr_cnt_o(nr_cnt_o), .to_cnt_o(to_cnt_o), .sp_cnt_o(sp_cnt_o),
      .cover_hits_o(cover_hits_o), .cover_full_o(cover_full_o),
      .cover_evt_o(cover_evt_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: transaction-level view with integer arithmetic and a set of covered pairs.
   bit  m_busy;
   int  m_elapsed;
   int  m_expect;
   bit  m_p[4];
   int  m_cnt[4];
   bit  m_evt[4];
   bit  m_cov[int];
   int  m_hits;
   localparam int SAT = (1 << CW) - 1;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input bit rs, dr, st, rd, dn, input int ph, mc, mp, pr);
      for (int i = 0; i < 4; i++) m_p[i] = 1'b0;
      if (rs) begin
         m_busy = 0; m_elapsed = 0; m_hits = 0; m_cov.delete();
         for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_evt[i] = 0; end
         return;
      end
      if (dr) begin
         if (ph == 1) m_evt[0] = 1;
         if (ph == 2) m_evt[1] = 1;
         m_busy = 0;
         return;
      end
      if (st && ph == 1) m_evt[2] = 1;
      if (st && ph == 2) m_evt[3] = 1;
      if (m_busy) begin
         if (dn) begin
            m_p[0] = (pr != m_expect);
            m_busy = 0;
         end else begin
            m_elapsed++;
            if (m_elapsed >= ML) begin m_p[2] = 1; m_busy = 0; end
         end
      end else if (dn) begin
         m_p[3] = 1;
      end
      if (st) begin
         if (rd) begin
            m_busy = 1; m_elapsed = 0; m_expect = mc * mp;
            if (mc < 16 && mp < 16 && !m_cov.exists(mc * 16 + mp)) begin
               m_cov[mc * 16 + mp] = 1;
               m_hits++;
            end
         end else begin
            m_p[1] = 1;
         end
      end
      for (int i = 0; i < 4; i++) if (m_p[i] && m_cnt[i] < SAT) m_cnt[i]++;
   endtask

   task automatic compare_all();
      chk("busy", busy_o, m_busy);
      chk("bp_err", bp_err_o, m_p[0]);
      chk("nr_err", nr_err_o, m_p[1]);
      chk("to_err", to_err_o, m_p[2]);
      chk("sp_err", sp_err_o, m_p[3]);
      chk("bp_cnt", bp_cnt_o, m_cnt[0]);
      chk("nr_cnt", nr_cnt_o, m_cnt[1]);
      chk("to_cnt", to_cnt_o, m_cnt[2]);
      chk("sp_cnt", sp_cnt_o, m_cnt[3]);
      chk("hits", cover_hits_o, m_hits);
      chk("full", cover_full_o, m_hits == 256);
      for (int i = 0; i < 4; i++) chk($sformatf("evt%0d", i), cover_evt_o[i], m_evt[i]);
   endtask

   task automatic step(input bit rs, dr, st, rd, dn, input int ph, mc, mp, pr);
      reset_i = rs; dut_rst_i = dr; start_i = st; ready_i = rd; done_i = dn;
      phase_i = 2'(ph); multiplicand_i = W'(mc); multiplier_i = W'(mp); product_i = 16'(pr);
      @(posedge clk);
      model(rs, dr, st, rd, dn, ph, mc, mp, pr);
      #1;
      compare_all();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic accept(input int mc, mp);
      step(0, 0, 1, 1, 0, 0, mc, mp, 0);
   endtask

   task automatic finish_op(input int pr);
      step(0, 0, 0, 0, 1, 0, 0, 0, pr);
   endtask

   typedef struct {
      int mc;
      int mp;
      int lat;
      int prod;
      bit bp;
   } vec_t;
   vec_t tbl[6];

   initial begin
      tbl[0] = '{mc: 3,   mp: 5,   lat: 10, prod: 15,    bp: 0};
      tbl[1] = '{mc: 7,   mp: 9,   lat: 4,  prod: 62,    bp: 1};
      tbl[2] = '{mc: 255, mp: 255, lat: 3,  prod: 65025, bp: 0};
      tbl[3] = '{mc: 0,   mp: 200, lat: 1,  prod: 0,     bp: 0};
      tbl[4] = '{mc: 128, mp: 2,   lat: 39, prod: 256,   bp: 0};
      tbl[5] = '{mc: 12,  mp: 12,  lat: 0,  prod: 143,   bp: 1};

      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1, 2, 3, 3, 0);
      chk("reset_busy", busy_o, 0);
      chk("reset_hits", cover_hits_o, 0);
      chk("reset_evt", cover_evt_o, 0);

      // Vector table: accept, wait, then done with the given product.
      for (int v = 0; v < 6; v++) begin
         accept(tbl[v].mc, tbl[v].mp);
         chk("tbl_busy_on", busy_o, 1);
         for (int k = 0; k < tbl[v].lat; k++) idle();
         finish_op(tbl[v].prod);
         chk($sformatf("tbl%0d_bp", v), bp_err_o, tbl[v].bp);
         chk($sformatf("tbl%0d_to", v), to_err_o, 0);
         chk($sformatf("tbl%0d_busy_off", v), busy_o, 0);
         idle();
      end
      chk("tbl_bp_cnt", bp_cnt_o, 2);
      chk("tbl_to_cnt", to_cnt_o, 0);
      chk("tbl_hits", cover_hits_o, 3);

      // Start while not ready in ADD phase.
      step(0, 0, 1, 0, 0, 1, 4, 4, 0);
      chk("nr_pulse", nr_err_o, 1);
      chk("nr_evt2", cover_evt_o[2], 1);
      chk("nr_busy", busy_o, 0);
      idle();
      chk("nr_pulse_clear", nr_err_o, 0);

      // Timeout on the 40th busy cycle, then a spurious done.
      accept(5, 6);
      for (int i = 1; i <= ML; i++) begin
         idle();
         chk("to_pulse", to_err_o, i == ML);
      end
      chk("to_idle", busy_o, 0);
      finish_op(30);
      chk("sp_pulse", sp_err_o, 1);
      chk("sp_no_bp", bp_err_o, 0);

      // Observed DUT reset in SHIFT while busy, with start/done also asserted.
      accept(2, 2);
      idle(); idle();
      step(0, 1, 1, 1, 1, 2, 9, 9, 0);
      chk("dr_busy", busy_o, 0);
      chk("dr_evt1", cover_evt_o[1], 1);
      chk("dr_no_err", {bp_err_o, nr_err_o, to_err_o, sp_err_o}, 0);
      step(0, 1, 0, 0, 0, 1, 0, 0, 0);
      chk("dr_evt0", cover_evt_o[0], 1);

      // Done and new start on the same edge, right then wrong product.
      accept(2, 3);
      step(0, 0, 1, 1, 1, 0, 4, 5, 6);
      chk("bb_bp_ok", bp_err_o, 0);
      chk("bb_busy", busy_o, 1);
      step(0, 0, 1, 1, 1, 0, 6, 7, 21);
      chk("bb_bp_bad", bp_err_o, 1);
      chk("bb_busy2", busy_o, 1);
      finish_op(42);
      chk("bb_done", busy_o, 0);

      // Full operand sweep for coverage, then repeats.
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++) begin
            accept(a, b);
            finish_op(a * b);
         end
      chk("sweep_hits", cover_hits_o, 256);
      chk("sweep_full", cover_full_o, 1);
      accept(3, 5); finish_op(15);
      accept(15, 15); finish_op(225);
      chk("repeat_hits", cover_hits_o, 256);

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         bit rs, dr, st, rd, dn;
         int ph, mc, mp, pr;
         rs = ($urandom_range(0, 999) == 0);
         dr = ($urandom_range(0, 49) == 0);
         st = ($urandom_range(0, 9) < 2);
         rd = ($urandom_range(0, 9) < 8);
         dn = ($urandom_range(0, 9) < 2);
         ph = int'($urandom_range(0, 3));
         mc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
         mp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
         pr = ($urandom_range(0, 3) != 0) ? m_expect : int'($urandom_range(0, 65535));
         step(rs, dr, st, rd, dn, ph, mc, mp, pr);
      end

      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("final_reset_cnt", bp_cnt_o + nr_cnt_o + to_cnt_o + sp_cnt_o, 0);
      chk("final_reset_full", cover_full_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
